// File: rtl/hgdb_bp_pkg.sv
// -----------------------------------------------------------------------------
// hgdb_bp_pkg
//   Shared types and defaults for the hgdb breakpoint monitor.
//   - bp_slot_t  : one breakpoint slot {enable, match_id, ignore} at default widths
//   - bp_state_e : monitor FSM state (RUN, HALT)
//   - slot_width : width of a slot index, never narrower than one bit
//   Optional feature macro used by importers: HGDB_BP_TIMESTAMP_EN
// -----------------------------------------------------------------------------
package hgdb_bp_pkg;

   localparam int DEF_NUM_SLOTS = 4;
   localparam int DEF_ID_WIDTH  = 16;
   localparam int DEF_CNT_WIDTH = 8;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } bp_state_e;

   typedef struct packed {
      logic                     enable;
      logic [DEF_ID_WIDTH-1:0]  match_id;
      logic [DEF_CNT_WIDTH-1:0] ignore;
   } bp_slot_t;

   // A single-slot build still needs a one-bit index port.
   function automatic int slot_width(input int num_slots);
      return (num_slots > 1) ? $clog2(num_slots) : 1;
   endfunction

endpackage

// File: rtl/hgdb_bp_monitor_if.sv
// -----------------------------------------------------------------------------
// hgdb_bp_monitor_if
//   Bundles the config, event and halt signals of the breakpoint monitor.
//   master : runtime / event tap side (drives cfg_*, evt_*, halt_ack)
//   slave  : hgdb_bp_monitor side (drives *_ready, halt_*, hit_count)
//   With HGDB_BP_TIMESTAMP_EN defined, halt_time (64-bit) is added.
// -----------------------------------------------------------------------------
interface hgdb_bp_monitor_if
   import hgdb_bp_pkg::*;
#(
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int ID_WIDTH  = DEF_ID_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
   localparam int SLOT_W = slot_width(NUM_SLOTS);

   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [SLOT_W-1:0]    cfg_slot;
   logic                 cfg_enable;
   logic [ID_WIDTH-1:0]  cfg_match_id;
   logic [CNT_WIDTH-1:0] cfg_ignore;

   logic                 evt_valid;
   logic                 evt_ready;
   logic [ID_WIDTH-1:0]  evt_id;

   logic                 halt_req;
   logic [SLOT_W-1:0]    halt_slot;
   logic [ID_WIDTH-1:0]  halt_id;
   logic                 halt_ack;
   logic [CNT_WIDTH-1:0] hit_count;
`ifdef HGDB_BP_TIMESTAMP_EN
   logic [63:0]          halt_time;
`endif

   modport master (
      output cfg_valid, cfg_slot, cfg_enable, cfg_match_id, cfg_ignore,
      output evt_valid, evt_id, halt_ack,
      input  cfg_ready, evt_ready, halt_req, halt_slot, halt_id,
`ifdef HGDB_BP_TIMESTAMP_EN
      input  halt_time,
`endif
      input  hit_count
   );

   modport slave (
      input  cfg_valid, cfg_slot, cfg_enable, cfg_match_id, cfg_ignore,
      input  evt_valid, evt_id, halt_ack,
      output cfg_ready, evt_ready, halt_req, halt_slot, halt_id,
`ifdef HGDB_BP_TIMESTAMP_EN
      output halt_time,
`endif
      output hit_count
   );

endinterface

// File: rtl/hgdb_bp_slot.sv
// -----------------------------------------------------------------------------
// hgdb_bp_slot
//   One breakpoint slot: holds enable/match_id/ignore, compares the accepted
//   event ID and either burns one ignore count or fires.
//   Ports: clk, rst (async, active-high); evt_accept/evt_id from the handshake;
//          cfg_we + cfg_enable/cfg_match_id/cfg_ignore for a config write;
//          fire (combinational, same cycle as the event handshake).
// -----------------------------------------------------------------------------
module hgdb_bp_slot #(
   parameter int ID_WIDTH  = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 evt_accept,
   input  logic [ID_WIDTH-1:0]  evt_id,
   input  logic                 cfg_we,
   input  logic                 cfg_enable,
   input  logic [ID_WIDTH-1:0]  cfg_match_id,
   input  logic [CNT_WIDTH-1:0] cfg_ignore,
   output logic                 fire
);
   logic                 enable;
   logic [ID_WIDTH-1:0]  match_id;
   logic [CNT_WIDTH-1:0] ignore;
   logic                 hit;

   assign hit  = evt_accept && enable && (match_id == evt_id);
   assign fire = hit && (ignore == '0);

   // A config write wins over a same-cycle decrement: the event already used
   // the old settings through 'fire', then the new settings replace them.
   // NOTE: state registers use non-blocking assignments so every slot samples
   // the same pre-edge values; each register here is small enough to reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable   <= 1'b0;
         match_id <= '0;
         ignore   <= '0;
      end else if (cfg_we) begin
         enable   <= cfg_enable;
         match_id <= cfg_match_id;
         ignore   <= cfg_ignore;
      end else if (hit && (ignore != '0)) begin
         ignore   <= ignore - CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/hgdb_bp_monitor.sv
// -----------------------------------------------------------------------------
// hgdb_bp_monitor
//   Breakpoint responder for the hgdb runtime. Watches the statement-event
//   stream, fires armed breakpoint slots and requests a halt; while halted the
//   event stream is backpressured until the runtime acknowledges.
//   Ports: clk, rst (async, active-high), bus (hgdb_bp_monitor_if.slave):
//          cfg_* config write channel, evt_* event channel,
//          halt_req/halt_slot/halt_id/halt_ack halt handshake, hit_count.
//   Optional: HGDB_BP_TIMESTAMP_EN adds halt_time, the free-running cycle
//             count latched when a breakpoint fires.
// -----------------------------------------------------------------------------
module hgdb_bp_monitor
   import hgdb_bp_pkg::*;
#(
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int ID_WIDTH  = DEF_ID_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   hgdb_bp_monitor_if.slave bus
);
   localparam int SLOT_W = slot_width(NUM_SLOTS);

   bp_state_e            state;
   logic                 evt_accept;
   logic                 cfg_accept;
   logic [NUM_SLOTS-1:0] fire;
   logic                 any_fire;
   logic [SLOT_W-1:0]    first_slot;

   logic                 halt_req_q;
   logic [SLOT_W-1:0]    halt_slot_q;
   logic [ID_WIDTH-1:0]  halt_id_q;
   logic [CNT_WIDTH-1:0] hit_count_q;

   // Readies depend on rst directly so they drop the moment reset asserts.
   assign bus.evt_ready = !rst && (state == RUN);
   assign bus.cfg_ready = !rst;
   assign evt_accept    = bus.evt_valid && bus.evt_ready;
   assign cfg_accept    = bus.cfg_valid && bus.cfg_ready;

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      hgdb_bp_slot #(
         .ID_WIDTH  (ID_WIDTH),
         .CNT_WIDTH (CNT_WIDTH)
      ) u_slot (
         .clk          (clk),
         .rst          (rst),
         .evt_accept   (evt_accept),
         .evt_id       (bus.evt_id),
         .cfg_we       (cfg_accept && (bus.cfg_slot == SLOT_W'(g))),
         .cfg_enable   (bus.cfg_enable),
         .cfg_match_id (bus.cfg_match_id),
         .cfg_ignore   (bus.cfg_ignore),
         .fire         (fire[g])
      );
   end

   // Lowest-index fired slot wins; scanning downward leaves it last-assigned.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      first_slot = '0;
      any_fire   = |fire;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (fire[i]) first_slot = SLOT_W'(i);
      end
   end

   // Fires can only occur in RUN because evt_ready is low in HALT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         halt_req_q  <= 1'b0;
         halt_slot_q <= '0;
         halt_id_q   <= '0;
         hit_count_q <= '0;
      end else begin
         case (state)
            RUN: begin
               if (any_fire) begin
                  state       <= HALT;
                  halt_req_q  <= 1'b1;
                  halt_slot_q <= first_slot;
                  halt_id_q   <= bus.evt_id;
                  if (hit_count_q != '1) hit_count_q <= hit_count_q + CNT_WIDTH'(1);
               end
            end
            HALT: begin
               if (bus.halt_ack) begin
                  state      <= RUN;
                  halt_req_q <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.halt_req  = halt_req_q;
   assign bus.halt_slot = halt_slot_q;
   assign bus.halt_id   = halt_id_q;
   assign bus.hit_count = hit_count_q;

`ifdef HGDB_BP_TIMESTAMP_EN
   logic [63:0] cycle_cnt;
   logic [63:0] halt_time_q;

   // Latched on exactly the same condition that updates halt_slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt   <= '0;
         halt_time_q <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if ((state == RUN) && any_fire) halt_time_q <= cycle_cnt;
      end
   end

   assign bus.halt_time = halt_time_q;
`endif

endmodule

// File: tb/tb_hgdb_bp_monitor.sv
// -----------------------------------------------------------------------------
// tb_hgdb_bp_monitor
//   Self-checking bench for hgdb_bp_monitor: directed scenarios with literal
//   expectations, then randomized traffic compared every cycle against a
//   behavioural model of the breakpoint rules.
// -----------------------------------------------------------------------------
module tb_hgdb_bp_monitor;
   import hgdb_bp_pkg::*;

   localparam int NUM_SLOTS = 4;
   localparam int ID_WIDTH  = 16;
   localparam int CNT_WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   hgdb_bp_monitor_if #(.NUM_SLOTS(NUM_SLOTS), .ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

   hgdb_bp_monitor #(.NUM_SLOTS(NUM_SLOTS), .ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bp_slot_t    mdl_slot [NUM_SLOTS];
   bit          mdl_halted;
   logic [1:0]  exp_slot;
   logic [15:0] exp_id;
   int          exp_hits;
   longint      mdl_cyc;
   longint      exp_time;

   always @(posedge clk or posedge rst) begin : model
      bp_slot_t nxt [NUM_SLOTS];
      int       first;
      bit       acc;
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) mdl_slot[i] <= '0;
         mdl_halted <= 1'b0;
         exp_slot   <= '0;
         exp_id     <= '0;
         exp_hits   <= 0;
         mdl_cyc    <= 0;
         exp_time   <= 0;
      end else begin
         nxt   = mdl_slot;
         first = -1;
         acc   = bus.evt_valid && !mdl_halted;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (acc && mdl_slot[i].enable && mdl_slot[i].match_id == bus.evt_id) begin
               if (mdl_slot[i].ignore != 0) nxt[i].ignore = mdl_slot[i].ignore - 8'd1;
               else if (first < 0) first = i;
            end
         end
         if (bus.cfg_valid)
            nxt[bus.cfg_slot] = '{bus.cfg_enable, bus.cfg_match_id, bus.cfg_ignore};
         mdl_slot <= nxt;
         if (mdl_halted) begin
            if (bus.halt_ack) mdl_halted <= 1'b0;
         end else if (first >= 0) begin
            mdl_halted <= 1'b1;
            exp_slot   <= first[1:0];
            exp_id     <= bus.evt_id;
            exp_hits   <= (exp_hits < 255) ? exp_hits + 1 : 255;
            exp_time   <= mdl_cyc;
         end
         mdl_cyc <= mdl_cyc + 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst) begin
         check("rst_evt_ready", bus.evt_ready, 0);
         check("rst_cfg_ready", bus.cfg_ready, 0);
         check("rst_halt_req",  bus.halt_req,  0);
         check("rst_hit_count", bus.hit_count, 0);
      end else begin
         check("evt_ready", bus.evt_ready, !mdl_halted);
         check("cfg_ready", bus.cfg_ready, 1);
         check("halt_req",  bus.halt_req,  mdl_halted);
         check("halt_slot", bus.halt_slot, exp_slot);
         check("halt_id",   bus.halt_id,   exp_id);
         check("hit_count", bus.hit_count, exp_hits);
`ifdef HGDB_BP_TIMESTAMP_EN
         check("halt_time", bus.halt_time, exp_time);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int slot, input bit en, input logic [15:0] id, input logic [7:0] ign);
      bus.cfg_valid    = 1'b1;
      bus.cfg_slot     = slot[1:0];
      bus.cfg_enable   = en;
      bus.cfg_match_id = id;
      bus.cfg_ignore   = ign;
      tick();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic send_evt(input logic [15:0] id);
      bus.evt_valid = 1'b1;
      bus.evt_id    = id;
      tick();
      bus.evt_valid = 1'b0;
   endtask

   task automatic ack();
      bus.halt_ack = 1'b1;
      tick();
      bus.halt_ack = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bus.cfg_valid    = 1'b0;
      bus.cfg_slot     = '0;
      bus.cfg_enable   = 1'b0;
      bus.cfg_match_id = '0;
      bus.cfg_ignore   = '0;
      bus.evt_valid    = 1'b0;
      bus.evt_id       = '0;
      bus.halt_ack     = 1'b0;

      #1;
      check("reset_halt_req", bus.halt_req, 0);
      check("reset_evt_ready", bus.evt_ready, 0);
      check("reset_hit_count", bus.hit_count, 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Basic fire and resume
      cfg_write(0, 1, 16'h0010, 0);
      send_evt(16'h0010);
      check("t1_halt_req",  bus.halt_req,  1);
      check("t1_halt_slot", bus.halt_slot, 0);
      check("t1_halt_id",   bus.halt_id,   16'h0010);
      check("t1_evt_ready", bus.evt_ready, 0);
      check("t1_hit_count", bus.hit_count, 1);
      ack();
      check("t1_ack_halt_req",  bus.halt_req,  0);
      check("t1_ack_evt_ready", bus.evt_ready, 1);

      // Ignore count of 2: third match fires
      cfg_write(1, 1, 16'h0022, 2);
      send_evt(16'h0022);
      check("t2_skip1", bus.halt_req, 0);
      send_evt(16'h0022);
      check("t2_skip2", bus.halt_req, 0);
      send_evt(16'h0022);
      check("t2_fire_req",  bus.halt_req,  1);
      check("t2_fire_slot", bus.halt_slot, 1);
      check("t2_hit_count", bus.hit_count, 2);
      ack();

      // Two slots with the same ID: lowest index reported, one hit counted
      cfg_write(2, 1, 16'h0005, 0);
      cfg_write(3, 1, 16'h0005, 0);
      send_evt(16'h0005);
      check("t3_slot",      bus.halt_slot, 2);
      check("t3_hit_count", bus.hit_count, 3);
      ack();
      send_evt(16'h0005);
      check("t3_slot_again", bus.halt_slot, 2);
      check("t3_hit_again",  bus.hit_count, 4);
      ack();

      // Same-cycle disable and matching event: old config fires once
      bus.cfg_valid    = 1'b1;
      bus.cfg_slot     = 2'd0;
      bus.cfg_enable   = 1'b0;
      bus.cfg_match_id = 16'h0010;
      bus.cfg_ignore   = 8'd0;
      bus.evt_valid    = 1'b1;
      bus.evt_id       = 16'h0010;
      tick();
      bus.cfg_valid = 1'b0;
      bus.evt_valid = 1'b0;
      check("t4_fire_req",  bus.halt_req,  1);
      check("t4_fire_slot", bus.halt_slot, 0);
      // A config write while halted keeps the halt
      cfg_write(1, 1, 16'h0022, 0);
      check("t4_cfg_in_halt", bus.halt_req, 1);
      ack();
      send_evt(16'h0010);
      check("t4_disabled", bus.halt_req, 0);

      // Saturate hit_count
      for (int i = 0; i < 260; i++) begin
         send_evt(16'h0005);
         ack();
      end
      check("t5_saturate", bus.hit_count, 255);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bus.cfg_valid    = ($urandom_range(0, 7) == 0);
         bus.cfg_slot     = 2'($urandom_range(0, NUM_SLOTS - 1));
         bus.cfg_enable   = ($urandom_range(0, 3) != 0);
         bus.cfg_match_id = 16'($urandom_range(0, 7));
         bus.cfg_ignore   = 8'($urandom_range(0, 3));
         bus.evt_valid    = $urandom_range(0, 1) == 1;
         bus.evt_id       = 16'($urandom_range(0, 7));
         bus.halt_ack     = ($urandom_range(0, 2) == 0);
         tick();
      end
      bus.cfg_valid = 1'b0;
      bus.evt_valid = 1'b0;
      bus.halt_ack  = 1'b1;
      tick();
      bus.halt_ack  = 1'b0;

      // Reset in the middle of a halt
      cfg_write(0, 1, 16'h0010, 0);
      send_evt(16'h0010);
      check("t6_pre_rst_halt", bus.halt_req, 1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_halt_req",  bus.halt_req,  0);
      check("t6_rst_hit_count", bus.hit_count, 0);
      check("t6_rst_evt_ready", bus.evt_ready, 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      send_evt(16'h0010);
      check("t6_post_rst_no_halt", bus.halt_req, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hgdb_bp_monitor.md
Name: hgdb_bp_monitor

Overview:
- RTL-side responder for the hgdb runtime: the runtime, driven through DPI from the testbench, programs breakpoint slots; the block watches the instrumented statement-event stream and raises a halt request when an armed breakpoint fires.
- Sits between the instrumented design's event tap and the hgdb DPI shim.
- Provides cycle-accurate breakpoint hits with ignore-counts and backpressures the event stream while halted.

Parameters:
- NUM_SLOTS, 4, number of breakpoint slots (1..16)
- ID_WIDTH, 16, width of statement/breakpoint ID
- CNT_WIDTH, 8, width of ignore-count and hit counter

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready
- cfg_slot  in  $clog2(NUM_SLOTS)  slot index
- cfg_enable  in  1  slot enable
- cfg_match_id  in  ID_WIDTH  statement ID to match
- cfg_ignore  in  CNT_WIDTH  matches to skip before firing
- evt_valid  in  1  statement event present
- evt_ready  out  1  event accepted when evt_valid & evt_ready
- evt_id  in  ID_WIDTH  statement ID of event
- halt_req  out  1  breakpoint hit; simulation must halt
- halt_slot  out  $clog2(NUM_SLOTS)  slot that fired
- halt_id  out  ID_WIDTH  event ID that fired
- halt_ack  in  1  runtime resumes
- hit_count  out  CNT_WIDTH  total hits since reset, saturating

Behaviour:
- Reset (async, rst=1):
  - all slots disabled; match_id and ignore cleared; FSM=RUN.
  - halt_req=0, halt_slot=0, halt_id=0, hit_count=0.
  - cfg_ready=0 and evt_ready=0 while rst is high.
- FSM states RUN, HALT:
  - RUN: evt_ready=1, cfg_ready=1.
  - RUN->HALT: on an accepted event that fires at least one slot.
  - HALT: evt_ready=0, cfg_ready=1, halt_req=1.
  - HALT->RUN: on halt_ack=1; halt_req is 0 the next cycle.
  - halt_ack in RUN is ignored.
- Match: accepted event, slot enabled, and match_id==evt_id.
  - Matched slot with ignore>0: decrement ignore; slot does not fire.
  - Matched slot with ignore==0: slot fires.
  - All matched slots update independently in the same cycle.
- Multiple fires: lowest slot index reported in halt_slot.
  - Other fired slots stay enabled with ignore=0 and fire on their next match.
- Latency: halt_req, halt_slot and halt_id are registered, visible the cycle after the event handshake.
  - halt_slot and halt_id hold until the next fire.
- hit_count:
  - +1 per cycle in which at least one slot fires (not per slot).
  - Saturates at 2^CNT_WIDTH-1.
- Slots stay armed after firing; only a config write disables a slot.
- Config write lands one cycle after the handshake.
  - Same-cycle event and config write to the same slot: the event uses the old config, then the write overwrites enable, match_id and ignore (any decrement is lost).
  - A config write during HALT is allowed and does not clear halt_req.
- Reset mid-HALT: halt_req drops asynchronously and all state clears.

Optional Feature:
- Macro HGDB_BP_TIMESTAMP_EN.
- Defined:
  - adds output halt_time (64-bit); a free-running cycle counter, reset to 0, wraps at 2^64.
  - halt_time is latched in the same cycle halt_slot is updated.
- Undefined: no counter and no port; behaviour otherwise identical.

Decomposition:
- Shared package hgdb_bp_pkg:
  - typedef bp_slot_t {enable, match_id, ignore}
  - typedef enum bp_state_e {RUN, HALT}
  - default parameter constants
- Sub-module hgdb_bp_slot: one instance per slot; holds slot state and compare/decrement logic; outputs fire.
- Top level: priority encoder, FSM, counters.

Test Plan:
- Program slot0 id=0x0010 ignore=0; send evt_id 0x0010 -> halt_req=1 next cycle, halt_slot=0, halt_id=0x0010, evt_ready=0, hit_count=1; halt_ack -> halt_req=0 and evt_ready=1 next cycle.
- Slot1 id=0x0022 ignore=2; send 0x0022 three times, acking each halt -> no halt for the first two; third halts with halt_slot=1.
- Slot2 and slot3 both id=0x0005; send one event -> halt_slot=2, hit_count +1; ack, send 0x0005 again -> halt_slot=2 again.
- Same cycle: config write disabling slot0 while event 0x0010 arrives -> halt fires once; later 0x0010 events produce no halt.
- Assert rst while halt_req=1 -> halt_req=0 immediately, hit_count=0; post-reset event 0x0010 -> no halt.
- 256 fires with CNT_WIDTH=8 -> hit_count saturates at 255; with HGDB_BP_TIMESTAMP_EN, fire at cycle 100 after reset -> halt_time=100.
